// File: rtl/ccg_pkg.sv
// Shared types and helpers for the CCG truth-table sweep controller.
package ccg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } ccg_tt_state_e;

  localparam int CCG_SETTLE_W = 8;

  function automatic int ccg_tt_bits(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/ccg_tt_sweep_ctrl_timer.sv
// Loadable settle down-counter; tc is high while the count is zero.
module ccg_settle_timer
  import ccg_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    en,
  input  logic [CCG_SETTLE_W-1:0] load_val,
  output logic                    tc
);

  logic [CCG_SETTLE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CCG_SETTLE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/ccg_tt_sweep_ctrl.sv
// Drives every input vector onto a CCG netlist, waits SETTLE cycles, and captures f1 into tt.
// Optional compare against an expected table is compiled in with CCG_TT_CMP_EN.
module ccg_tt_sweep_ctrl
  import ccg_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int SETTLE = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            abort,
  output logic [N_IN-1:0]                 x,
  input  logic                            f_in,
  output logic                            busy,
  output logic                            done,
  output logic [ccg_tt_bits(N_IN)-1:0]    tt
`ifdef CCG_TT_CMP_EN
  ,
  input  logic [ccg_tt_bits(N_IN)-1:0]    exp_tt,
  output logic                            mismatch,
  output logic [N_IN-1:0]                 mis_idx
`endif
);

  localparam int                      TT_W      = ccg_tt_bits(N_IN);
  localparam logic [N_IN:0]           LAST_IDX  = (N_IN+1)'(TT_W - 1);
  localparam logic [CCG_SETTLE_W-1:0] SETTLE_LD = CCG_SETTLE_W'(SETTLE - 1);

  ccg_tt_state_e   state_q, state_d;
  logic [N_IN:0]   idx_q, idx_d;
  logic [N_IN-1:0] x_q, x_d;
  logic [TT_W-1:0] tt_q, tt_d, tt_cap;
  logic            tmr_load, tmr_tc;
  logic            start_acc, fin;

  assign start_acc = (state_q == ST_IDLE) && start && !abort;
  assign fin       = (state_q == ST_CAPTURE) && !abort && (idx_q == LAST_IDX);

  ccg_settle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .en       (state_q == ST_SETTLE),
    .load_val (SETTLE_LD),
    .tc       (tmr_tc)
  );

  always_comb begin
    tt_cap = tt_q;
    tt_cap[idx_q[N_IN-1:0]] = f_in;
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    x_d      = x_q;
    tt_d     = tt_q;
    tmr_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_acc) begin
          idx_d    = '0;
          x_d      = '0;
          tt_d     = '0;
          tmr_load = 1'b1;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          x_d     = '0;
          state_d = ST_IDLE;
        end else if (tmr_tc) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (abort) begin
          x_d     = '0;
          state_d = ST_IDLE;
        end else begin
          tt_d = tt_cap;
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d    = idx_q + (N_IN+1)'(1);
            x_d      = idx_q[N_IN-1:0] + N_IN'(1);
            tmr_load = 1'b1;
            state_d  = ST_SETTLE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      x_q     <= '0;
      tt_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      tt_q    <= tt_d;
    end
  end

  assign x    = x_q;
  assign tt   = tt_q;
  assign busy = (state_q == ST_SETTLE) || (state_q == ST_CAPTURE);
  assign done = (state_q == ST_DONE);

`ifdef CCG_TT_CMP_EN
  logic [TT_W-1:0] exp_q, exp_d, diff;
  logic            mismatch_q, mismatch_d;
  logic [N_IN-1:0] mis_idx_q, mis_idx_d, low_idx;

  // Lowest differing index wins, so scan from the top down.
  always_comb begin
    diff    = tt_cap ^ exp_q;
    low_idx = '0;
    for (int i = TT_W - 1; i >= 0; i--) begin
      if (diff[i]) low_idx = N_IN'(i);
    end
  end

  always_comb begin
    exp_d      = exp_q;
    mismatch_d = mismatch_q;
    mis_idx_d  = mis_idx_q;
    if (start_acc) begin
      exp_d      = exp_tt;
      mismatch_d = 1'b0;
      mis_idx_d  = '0;
    end else if (fin) begin
      mismatch_d = |diff;
      mis_idx_d  = low_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q      <= '0;
      mismatch_q <= 1'b0;
      mis_idx_q  <= '0;
    end else begin
      exp_q      <= exp_d;
      mismatch_q <= mismatch_d;
      mis_idx_q  <= mis_idx_d;
    end
  end

  assign mismatch = mismatch_q;
  assign mis_idx  = mis_idx_q;
`endif

endmodule

// File: tb/tb_ccg_tt_sweep_ctrl.sv
// Randomized self-checking bench: two controllers (SETTLE=2 and SETTLE=1) against a cycle-count model.
module tb_ccg_tt_sweep_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start0 = 0, abort0 = 0, busy0, done0, f0;
  logic [3:0]  x0;
  logic [15:0] tt0, net0 = '0, exp0 = '0;
  logic        start1 = 0, abort1 = 0, busy1, done1, f1;
  logic [3:0]  x1;
  logic [15:0] tt1, net1 = '0, exp1 = '0;
`ifdef CCG_TT_CMP_EN
  logic       mis0, mis1;
  logic [3:0] misidx0, misidx1;
`endif

  assign f0 = net0[x0];
  assign f1 = net1[x1];

  int tests_run = 0;
  int tests_failed = 0;

  ccg_tt_sweep_ctrl #(.N_IN(4), .SETTLE(2)) u_dut (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0), .x(x0), .f_in(f0),
    .busy(busy0), .done(done0), .tt(tt0)
`ifdef CCG_TT_CMP_EN
    , .exp_tt(exp0), .mismatch(mis0), .mis_idx(misidx0)
`endif
  );

  ccg_tt_sweep_ctrl #(.N_IN(4), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .x(x1), .f_in(f1),
    .busy(busy1), .done(done1), .tt(tt1)
`ifdef CCG_TT_CMP_EN
    , .exp_tt(exp1), .mismatch(mis1), .mis_idx(misidx1)
`endif
  );

  function automatic logic [15:0] golden_nand12();
    logic [15:0] t;
    for (int i = 0; i < 16; i++) t[i] = !(((i >> 1) & 1) && ((i >> 2) & 1));
    return t;
  endfunction

  // One full sweep on instance sel, checked cycle by cycle. abort_edge < 0 means no abort.
  task automatic run_sweep(input int sel, input logic [15:0] tbl, input logic [15:0] exp_t,
                           input int abort_edge, input bit restart);
    int s, total, vec;
    logic        o_busy, o_done;
    logic [3:0]  o_x, e_x;
    logic [15:0] o_tt, e_part, diff;
    logic        e_mis, o_mis;
    logic [3:0]  e_idx, o_idx;
    s     = (sel != 0) ? 1 : 2;
    total = 16 * (s + 1);
    diff  = tbl ^ exp_t;
    e_mis = |diff;
    e_idx = 4'd0;
    for (int i = 15; i >= 0; i--) if (diff[i]) e_idx = 4'(i);
    e_part = '0;
    for (int i = 0; i < 16; i++) if ((i + 1) * (s + 1) < abort_edge) e_part[i] = tbl[i];
    if (sel != 0) begin net1 = tbl; exp1 = exp_t; end
    else          begin net0 = tbl; exp0 = exp_t; end
    @(negedge clk);
    if (sel != 0) start1 = 1; else start0 = 1;
    @(negedge clk);
    start0 = 0; start1 = 0;
    for (int n = 0; n <= total + 2; n++) begin
      o_x    = (sel != 0) ? x1 : x0;
      o_busy = (sel != 0) ? busy1 : busy0;
      o_done = (sel != 0) ? done1 : done0;
      o_tt   = (sel != 0) ? tt1 : tt0;
      o_mis  = 1'b0;
      o_idx  = 4'd0;
`ifdef CCG_TT_CMP_EN
      o_mis  = (sel != 0) ? mis1 : mis0;
      o_idx  = (sel != 0) ? misidx1 : misidx0;
`endif
      if (abort_edge >= 0 && n >= abort_edge) begin
        tests_run++;
        if (o_x !== 4'd0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
          tests_failed++;
          $display("FAIL abort_state n=%0d: x=%0d busy=%b done=%b, expected x=0 busy=0 done=0",
                   n, o_x, o_busy, o_done);
        end
        if (n == abort_edge + 3) begin
          tests_run++;
          if (o_tt !== e_part) begin
            tests_failed++;
            $display("FAIL abort_tt: got %h expected %h", o_tt, e_part);
          end
`ifdef CCG_TT_CMP_EN
          tests_run++;
          if (o_mis !== 1'b0 || o_idx !== 4'd0) begin
            tests_failed++;
            $display("FAIL abort_cmp: mismatch=%b mis_idx=%0d expected 0 0", o_mis, o_idx);
          end
`endif
          break;
        end
      end else begin
        vec = n / (s + 1);
        e_x = (n < total) ? 4'(vec) : 4'd15;
        tests_run++;
        if (o_x !== e_x || o_busy !== (n < total) || o_done !== (n == total)) begin
          tests_failed++;
          $display("FAIL sweep_timing n=%0d S=%0d: x=%0d busy=%b done=%b, expected x=%0d busy=%b done=%b",
                   n, s, o_x, o_busy, o_done, e_x, (n < total), (n == total));
        end
        if (n == total || n == total + 2) begin
          tests_run++;
          if (o_tt !== tbl) begin
            tests_failed++;
            $display("FAIL sweep_tt n=%0d S=%0d: got %h expected %h", n, s, o_tt, tbl);
          end
`ifdef CCG_TT_CMP_EN
          tests_run++;
          if (o_mis !== e_mis || o_idx !== e_idx) begin
            tests_failed++;
            $display("FAIL sweep_cmp n=%0d: mismatch=%b mis_idx=%0d expected %b %0d",
                     n, o_mis, o_idx, e_mis, e_idx);
          end
`endif
        end
      end
      if (sel != 0) begin
        start1 = restart && ((n + 1 == 5) || (n + 1 == 20));
        abort1 = (n + 1 == abort_edge);
      end else begin
        start0 = restart && ((n + 1 == 5) || (n + 1 == 20));
        abort0 = (n + 1 == abort_edge);
      end
      @(negedge clk);
    end
    start0 = 0; start1 = 0; abort0 = 0; abort1 = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    tests_run++;
    if (x0 !== 4'd0 || busy0 !== 1'b0 || done0 !== 1'b0 || tt0 !== 16'h0 ||
        x1 !== 4'd0 || busy1 !== 1'b0 || done1 !== 1'b0 || tt1 !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_values: x0=%0d busy0=%b done0=%b tt0=%h x1=%0d tt1=%h, expected all 0",
               x0, busy0, done0, tt0, x1, tt1);
    end
`ifdef CCG_TT_CMP_EN
    tests_run++;
    if (mis0 !== 1'b0 || misidx0 !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_cmp: mismatch=%b mis_idx=%0d expected 0 0", mis0, misidx0);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_golden();
    run_sweep(0, golden_nand12(), golden_nand12(), -1, 1'b0);
    run_sweep(0, golden_nand12(), golden_nand12() | 16'h0040, -1, 1'b0);
  endtask

  task automatic test_random();
    logic [15:0] t, e;
    for (int k = 0; k < 6; k++) begin
      t = 16'($urandom);
      e = ($urandom_range(1) == 0) ? t : (t ^ 16'($urandom));
      run_sweep(k % 2, t, e, -1, 1'b0);
    end
  endtask

  task automatic test_abort();
    run_sweep(0, golden_nand12(), 16'h0, 10, 1'b0);
    run_sweep(1, 16'($urandom), 16'($urandom), int'($urandom_range(3, 30)), 1'b0);
    run_sweep(0, golden_nand12(), golden_nand12(), -1, 1'b0);
  endtask

  task automatic test_start_ignored();
    run_sweep(0, golden_nand12(), golden_nand12(), -1, 1'b1);
  endtask

  task automatic test_async_reset();
    net0 = golden_nand12();
    @(negedge clk);
    start0 = 1;
    @(negedge clk);
    start0 = 0;
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (x0 !== 4'd0 || busy0 !== 1'b0 || done0 !== 1'b0 || tt0 !== 16'h0) begin
      tests_failed++;
      $display("FAIL async_reset: x=%0d busy=%b done=%b tt=%h, expected 0 0 0 0000",
               x0, busy0, done0, tt0);
    end
    @(negedge clk);
    rst = 1'b0;
    run_sweep(0, golden_nand12(), golden_nand12(), -1, 1'b0);
  endtask

  task automatic test_settle1();
    run_sweep(1, 16'hFFFF, 16'hFFFF, -1, 1'b0);
    run_sweep(1, 16'hFFFF, 16'h7FFF, -1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_golden();
    test_random();
    test_abort();
    test_start_ignored();
    test_async_reset();
    test_settle1();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
